div_unit: RTL and testbench

Iterative radix-2 divider for the execute stage of the 5-stage RV32M pipeline. It consumes the decode-stage divide controls, a start pulse and a 2-bit function select, once they reach EX. It produces the RISC-V DIV/DIVU/REM/REMU results over multiple cycles. While an operation is in flight it holds `busy` so the hazard unit can stall IF/ID/EX. It returns the result with a one-cycle `done` strobe and the destination-register tag for writeback.

---
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module div_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int FUNC_WIDTH     = 2,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_div,
   input  logic [FUNC_WIDTH-1:0]     div_func,
   input  logic                      flush,
   input  logic [DATA_WIDTH-1:0]     dividend,
   input  logic [DATA_WIDTH-1:0]     divisor,
   input  logic [REG_ADDR_WIDTH-1:0] rd_in,
   output logic                      busy,
   output logic                      done,
   output logic [DATA_WIDTH-1:0]     div_result,
   output logic [REG_ADDR_WIDTH-1:0] rd_out
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

   state_t                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [DATA_WIDTH-1:0]     rem_q, quo_q, dvsr_q, result_q;
   logic [REG_ADDR_WIDTH-1:0] rd_tag_q, rd_out_q;
   logic                      is_rem_q, dvd_neg_q, dvs_neg_q;
   logic                      busy_q, done_q;

   // Operand decode at start acceptance; func[0]=1 marks the unsigned variants.
   logic                  is_signed, is_rem, dvd_neg, dvs_neg, div_zero, overflow;
   logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag, special_res;

   assign is_signed = ~div_func[0];
   assign is_rem    = div_func[1];
   assign dvd_neg   = is_signed & dividend[DATA_WIDTH-1];
   assign dvs_neg   = is_signed & divisor[DATA_WIDTH-1];
   assign dvd_mag   = dvd_neg ? -dividend : dividend;
   assign dvs_mag   = dvs_neg ? -divisor  : divisor;
   assign div_zero  = (divisor == '0);
   assign overflow  = is_signed && (dividend == MOST_NEG) && (divisor == '1);

   always_comb begin
      // NOTE: default assignment first so no path leaves special_res unassigned (no latch).
      special_res = '0;
      if (div_zero)     special_res = is_rem ? dividend : '1;
      else if (overflow) special_res = is_rem ? '0 : dividend;
   end

   // One restoring step: shift {rem,quo}, trial-subtract with one extra bit for the sign.
   logic [DATA_WIDTH:0]   rem_shift, trial;
   logic [DATA_WIDTH-1:0] rem_d, quo_d, quo_fix, rem_fix, result_d;

   assign rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
   assign trial     = rem_shift - {1'b0, dvsr_q};
   assign rem_d     = trial[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
   assign quo_d     = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
   assign quo_fix   = (dvd_neg_q ^ dvs_neg_q) ? -quo_d : quo_d;
   assign rem_fix   = dvd_neg_q ? -rem_d : rem_d;
   assign result_d  = is_rem_q ? rem_fix : quo_fix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         result_q  <= '0;
         rd_tag_q  <= '0;
         rd_out_q  <= '0;
         is_rem_q  <= 1'b0;
         dvd_neg_q <= 1'b0;
         dvs_neg_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else if (flush) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_div) begin
                  rd_tag_q  <= rd_in;
                  is_rem_q  <= is_rem;
                  dvd_neg_q <= dvd_neg;
                  dvs_neg_q <= dvs_neg;
                  dvsr_q    <= dvs_mag;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  if (div_zero || overflow) begin
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                     result_q <= special_res;
                     rd_out_q <= rd_in;
                  end else begin
                     state_q <= S_DIVIDE;
                     rem_q   <= '0;
                     quo_q   <= dvd_mag;
                  end
               end
            end
            S_DIVIDE: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_STEP) begin
                  state_q  <= S_DONE;
                  done_q   <= 1'b1;
                  result_q <= result_d;
                  rd_out_q <= rd_tag_q;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign div_result = result_q;
   assign rd_out     = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a cycle-level reference model compared every cycle,
// plus directed operations with hand-computed results.
module tb_div_unit;

   localparam int DW = 32;
   localparam int FW = 2;
   localparam int RW = 5;
   localparam logic [1:0] F_DIV = 2'b00, F_DIVU = 2'b01, F_REM = 2'b10, F_REMU = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_div = 1'b0;
   logic          flush = 1'b0;
   logic [FW-1:0] div_func = '0;
   logic [DW-1:0] dividend = '0;
   logic [DW-1:0] divisor = '0;
   logic [RW-1:0] rd_in = '0;
   logic          busy, done;
   logic [DW-1:0] div_result;
   logic [RW-1:0] rd_out;

   int checks = 0;
   int errors = 0;

   div_unit #(.DATA_WIDTH(DW), .FUNC_WIDTH(FW), .REG_ADDR_WIDTH(RW)) dut (
      .clk(clk), .rst_n(rst_n), .start_div(start_div), .div_func(div_func),
      .flush(flush), .dividend(dividend), .divisor(divisor), .rd_in(rd_in),
      .busy(busy), .done(done), .div_result(div_result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural RV32M semantics in plain integer arithmetic.
   function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
      if (!f[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
         return f[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return f[1] ? a % b : a / b;
   endfunction

   function automatic bit ref_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Timing model: m_left counts the cycles until the unit is idle again; done when it is 1.
   int          m_left = 0;
   logic [31:0] m_res = '0, m_pend_res = '0;
   logic [4:0]  m_rd = '0, m_pend_rd = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left = 0;
         m_res  = '0;
         m_rd   = '0;
      end else if (flush) begin
         m_left = 0;
      end else if (m_left == 0) begin
         if (start_div) begin
            m_pend_res = ref_div(div_func, dividend, divisor);
            m_pend_rd  = rd_in;
            m_left     = ref_special(div_func, dividend, divisor) ? 1 : DW + 1;
         end
      end else begin
         m_left--;
      end
      if (rst_n && m_left == 1) begin
         m_res = m_pend_res;
         m_rd  = m_pend_rd;
      end
   end

   always @(negedge clk) begin
      check("cmp_busy",   32'(busy),       32'(m_left > 0));
      check("cmp_done",   32'(done),       32'(m_left == 1));
      check("cmp_result", div_result,      m_res);
      check("cmp_rd",     32'(rd_out),     32'(m_rd));
   end

   task automatic wait_done(output int n, output int bcnt);
      n = 0;
      bcnt = 0;
      for (int i = 0; i < DW + 8; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) break;
         n++;
      end
   endtask

   // Called at posedge+2; holds start until done, returns at posedge+2 of the cycle after done.
   task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] lit, input int lat);
      int n, bcnt;
      check("model_pin", ref_div(f, a, b), lit);
      div_func  = f;
      dividend  = a;
      divisor   = b;
      rd_in     = rd;
      start_div = 1'b1;
      wait_done(n, bcnt);
      check("done_cycle",  32'(n),    32'(lat));
      check("busy_cycles", 32'(bcnt), 32'(lat));
      check("result",      div_result, lit);
      check("rd_out",      32'(rd_out), 32'(rd));
      @(posedge clk); #2;
      start_div = 1'b0;
   endtask

   initial begin
      int n, bcnt;
      repeat (3) @(posedge clk);
      #2;
      check("rst_busy",   32'(busy),   0);
      check("rst_done",   32'(done),   0);
      check("rst_result", div_result,  0);
      check("rst_rd",     32'(rd_out), 0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      run_op(F_DIV,  32'd100,       32'hFFFF_FFF9, 5'd5,  32'hFFFF_FFF2, 33);
      run_op(F_REM,  32'hFFFF_FF9C, 32'd7,         5'd6,  32'hFFFF_FFFE, 33);
      // 4294967196 = 7 * 613566742 + 2
      run_op(F_REMU, 32'hFFFF_FF9C, 32'd7,         5'd7,  32'h0000_0002, 33);
      run_op(F_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd16, 32'd14,        33);
      run_op(F_DIVU, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'h7FFF_FFFF, 33);
      run_op(F_REMU, 32'hFFFF_FFFF, 32'd2,         5'd10, 32'h0000_0001, 33);
      repeat (10) @(posedge clk);
      #2;
      check("held_result", div_result,  32'h1);
      check("held_rd",     32'(rd_out), 32'd10);

      run_op(F_DIV,  32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1);
      run_op(F_REM,  32'd5,         32'd0,         5'd12, 32'h0000_0005, 1);
      run_op(F_DIVU, 32'd9,         32'd0,         5'd15, 32'hFFFF_FFFF, 1);
      run_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
      run_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1);

      // A fresh start pulse with other operands mid-operation must be ignored.
      div_func = F_DIVU; dividend = 32'd1000; divisor = 32'd3; rd_in = 5'd9; start_div = 1'b1;
      repeat (4) @(negedge clk);
      start_div = 1'b0;
      @(negedge clk);
      div_func = F_REM; dividend = 32'd77; divisor = 32'd5; rd_in = 5'd20; start_div = 1'b1;
      wait_done(n, bcnt);
      check("ignore_done_cycle", 32'(n + 5), 33);
      check("ignore_result",     div_result,  32'd333);
      check("ignore_rd",         32'(rd_out), 32'd9);
      @(posedge clk); #2;
      start_div = 1'b0;

      // Flush in cycle 10 of DIVIDE: idle next cycle, no done, old result kept.
      div_func = F_DIV; dividend = 32'd500; divisor = 32'd7; rd_in = 5'd3; start_div = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      flush = 1'b1;
      start_div = 1'b0;
      @(posedge clk); #2;
      flush = 1'b0;
      check("flush_busy", 32'(busy), 0);
      repeat (DW + 5) @(posedge clk);
      #2;
      check("flush_result", div_result,  32'd333);
      check("flush_rd",     32'(rd_out), 32'd9);

      // Flush in cycle 3, then a start in the very next cycle is accepted.
      div_func = F_DIVU; dividend = 32'd7; divisor = 32'd2; rd_in = 5'd1; start_div = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      flush = 1'b1;
      start_div = 1'b0;
      @(posedge clk); #2;
      flush = 1'b0;
      run_op(F_DIVU, 32'd45, 32'd4, 5'd4, 32'd11, 33);

      // Flush and start together in IDLE: nothing accepted.
      div_func = F_DIV; dividend = 32'd6; divisor = 32'd0; rd_in = 5'd2;
      start_div = 1'b1;
      flush = 1'b1;
      @(posedge clk); #2;
      start_div = 1'b0;
      flush = 1'b0;
      check("fs_busy", 32'(busy), 0);
      check("fs_done", 32'(done), 0);
      repeat (3) @(posedge clk);
      #2;
      check("fs_result", div_result, 32'd11);

      // Reset in cycle 20 of an operation clears outputs at once; no done afterwards.
      div_func = F_DIVU; dividend = 32'd1000; divisor = 32'd3; rd_in = 5'd30; start_div = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      start_div = 1'b0;
      #1;
      check("mid_rst_busy",   32'(busy),   0);
      check("mid_rst_done",   32'(done),   0);
      check("mid_rst_result", div_result,  0);
      check("mid_rst_rd",     32'(rd_out), 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (DW + 5) @(posedge clk);
      #2;
      check("post_rst_result", div_result,  0);
      check("post_rst_busy",   32'(busy),   0);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
